// File: rtl/image_pkg.sv
//------------------------------------------------------------------------------
// Module  : image_pkg
// Purpose : Shared FSM state encoding and default frame geometry for the
//           image_stream frame buffer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package image_pkg;

  // Controller states: idle, accepting a frame, streaming the stored frame
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // Default geometry: 28x28 single-channel 8-bit images
  localparam int c_def_pix_w    = 8;
  localparam int c_def_channels = 1;
  localparam int c_def_img_w    = 28;
  localparam int c_def_img_h    = 28;

endpackage

`default_nettype wire

// File: rtl/image_stream_if.sv
//------------------------------------------------------------------------------
// Module  : image_stream_if
// Purpose : Load (in_*) and stream (out_*) valid/ready channels of the
//           image_stream frame buffer. slave = frame buffer side.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface image_stream_if
  import image_pkg::*;
#(
  parameter int PIX_W    = c_def_pix_w,
  parameter int CHANNELS = c_def_channels
);

  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*PIX_W-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS*PIX_W-1:0] out_data;
  logic                      out_eol;
  logic                      out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_eol, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_eol, out_last
  );

endinterface

`default_nettype wire

// File: rtl/image_ram.sv
//------------------------------------------------------------------------------
// Module  : image_ram
// Purpose : Simple dual-port synchronous RAM, one write port and one
//           registered read port. Contents are never reset.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module image_ram #(
  parameter int DEPTH = 784,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port and registered read port; read data only changes on i_re
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/image_stream.sv
//------------------------------------------------------------------------------
// Module  : image_stream
// Purpose : Frame buffer. Loads IMG_W*IMG_H pixels over a valid/ready port,
//           then replays the stored frame in raster order on request with
//           row (out_eol) and frame (out_last) markers.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module image_stream
  import image_pkg::*;
#(
  parameter int PIX_W    = c_def_pix_w,
  parameter int CHANNELS = c_def_channels,
  parameter int IMG_W    = c_def_img_w,
  parameter int IMG_H    = c_def_img_h
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          start,
  output logic          frame_loaded,
  output logic          busy,
  image_stream_if.slave bus
);

  localparam int c_depth = IMG_W * IMG_H;
  localparam int c_dw    = CHANNELS * PIX_W;
  localparam int c_aw    = $clog2(c_depth);
  localparam int c_cw    = $clog2(IMG_W);
  localparam int c_rw    = $clog2(IMG_H);

  localparam logic [c_aw-1:0] c_last_addr = c_aw'(c_depth - 1);
  localparam logic [c_cw-1:0] c_last_col  = c_cw'(IMG_W - 1);
  localparam logic [c_rw-1:0] c_last_row  = c_rw'(IMG_H - 1);

  state_t            r_state;
  logic              r_frame_loaded;
  logic              r_in_ready;
  logic              r_busy;
  logic [c_aw-1:0]   r_wr_addr;
  logic [c_aw-1:0]   r_rd_addr;
  logic [c_cw-1:0]   r_col;
  logic [c_rw-1:0]   r_row;
  logic              r_rd_done;

  // Read pipeline: RAM output (one cycle after issue), skid entry, output reg
  logic              r_rd_pend;
  logic              r_rd_eol;
  logic              r_rd_last;
  logic              r_skid_v;
  logic [c_dw-1:0]   r_skid_data;
  logic              r_skid_eol;
  logic              r_skid_last;
  logic              r_out_valid;
  logic [c_dw-1:0]   r_out_data;
  logic              r_out_eol;
  logic              r_out_last;

  logic              w_accept;
  logic              w_start_ok;
  logic              w_pop;
  logic              w_out_load;
  logic [1:0]        w_occ;
  logic              w_room;
  logic              w_issue;
  logic [c_dw-1:0]   w_ram_rdata;

  assign w_accept   = bus.in_valid & r_in_ready & ~flush;
  assign w_start_ok = start & ~flush & (r_state == ST_IDLE) & r_frame_loaded;
  assign w_pop      = r_out_valid & bus.out_ready;
  assign w_out_load = ~r_out_valid | bus.out_ready;

  // Pixels in flight or held; a new read may issue only if it is certain to
  // find a free slot (skid or output register) when its data emerges.
  assign w_occ  = 2'(r_rd_pend) + 2'(r_skid_v) + 2'(r_out_valid);
  assign w_room = (w_occ <= 2'd1) || (w_pop && (w_occ == 2'd2));

  // The first read issues in the start cycle itself so data reaches the
  // output register two cycles after start.
  assign w_issue = ~flush & (w_start_ok |
                   ((r_state == ST_STREAM) & ~r_rd_done & w_room));

  image_ram #(
    .DEPTH (c_depth),
    .WIDTH (c_dw)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_wr_addr),
    .i_wdata (bus.in_data),
    .i_re    (w_issue),
    .i_raddr (r_rd_addr),
    .o_rdata (w_ram_rdata)
  );

  // Controller FSM with load counter, read issue counters and output pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_frame_loaded <= 1'b0;
      r_in_ready     <= 1'b0;
      r_busy         <= 1'b0;
      r_wr_addr      <= '0;
      r_rd_addr      <= '0;
      r_col          <= '0;
      r_row          <= '0;
      r_rd_done      <= 1'b0;
      r_rd_pend      <= 1'b0;
      r_rd_eol       <= 1'b0;
      r_rd_last      <= 1'b0;
      r_skid_v       <= 1'b0;
      r_skid_data    <= '0;
      r_skid_eol     <= 1'b0;
      r_skid_last    <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_eol      <= 1'b0;
      r_out_last     <= 1'b0;
    end else if (flush) begin
      r_state        <= ST_IDLE;
      r_frame_loaded <= 1'b0;
      r_in_ready     <= 1'b1;
      r_busy         <= 1'b0;
      r_wr_addr      <= '0;
      r_rd_addr      <= '0;
      r_col          <= '0;
      r_row          <= '0;
      r_rd_done      <= 1'b0;
      r_rd_pend      <= 1'b0;
      r_skid_v       <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_eol      <= 1'b0;
      r_out_last     <= 1'b0;
    end else begin
      r_in_ready <= ~r_frame_loaded;

      // Read issue: tag each pixel with its row/frame markers at issue time
      r_rd_pend <= w_issue;
      if (w_issue) begin
        r_rd_eol  <= (r_col == c_last_col);
        r_rd_last <= (r_col == c_last_col) && (r_row == c_last_row);
        if (r_rd_addr == c_last_addr) begin
          r_rd_done <= 1'b1;
        end else begin
          r_rd_addr <= r_rd_addr + c_aw'(1);
        end
        if (r_col == c_last_col) begin
          r_col <= '0;
          if (r_row != c_last_row) begin
            r_row <= r_row + c_rw'(1);
          end
        end else begin
          r_col <= r_col + c_cw'(1);
        end
      end

      // Output register refills from the older skid entry first
      if (w_out_load) begin
        if (r_skid_v) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_skid_data;
          r_out_eol   <= r_skid_eol;
          r_out_last  <= r_skid_last;
        end else if (r_rd_pend) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_ram_rdata;
          r_out_eol   <= r_rd_eol;
          r_out_last  <= r_rd_last;
        end else begin
          r_out_valid <= 1'b0;
          r_out_eol   <= 1'b0;
          r_out_last  <= 1'b0;
        end
      end

      // RAM data that cannot enter the output register parks in the skid
      if ((w_out_load && r_skid_v) || (!w_out_load && r_rd_pend)) begin
        r_skid_v <= r_rd_pend;
        if (r_rd_pend) begin
          r_skid_data <= w_ram_rdata;
          r_skid_eol  <= r_rd_eol;
          r_skid_last <= r_rd_last;
        end
      end

      case (r_state)
        ST_IDLE, ST_LOAD: begin
          if (w_accept) begin
            if (r_wr_addr == c_last_addr) begin
              r_frame_loaded <= 1'b1;
              r_in_ready     <= 1'b0;
              r_wr_addr      <= '0;
              r_state        <= ST_IDLE;
            end else begin
              r_wr_addr <= r_wr_addr + c_aw'(1);
              r_state   <= ST_LOAD;
            end
          end
          if (w_start_ok) begin
            r_state <= ST_STREAM;
            r_busy  <= 1'b1;
          end
        end
        ST_STREAM: begin
          // Frame done once the last pixel is handed off; the frame stays
          // loaded so another start replays it.
          if (w_pop && r_out_last) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_rd_addr <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_rd_done <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign frame_loaded  = r_frame_loaded;
  assign busy          = r_busy;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_eol   = r_out_eol;
  assign bus.out_last  = r_out_last;

endmodule

`default_nettype wire
